// File: rtl/temp_filter_pkg.sv
// Shared constants and types for the temperature sample filter.
package temp_filter_pkg;

  // Width of one raw XADC conversion code.
  localparam int TEMP_W = 12;

  // Default over-temperature hysteresis thresholds (filtered code).
  localparam logic [TEMP_W-1:0] HI_THRESH_DEF = 12'd2500;
  localparam logic [TEMP_W-1:0] LO_THRESH_DEF = 12'd2400;

  // Over-temperature hysteresis state.
  typedef enum logic {
    OT_OK  = 1'b0,
    OT_HOT = 1'b1
  } ot_state_e;

endpackage : temp_filter_pkg

// File: rtl/temp_sample_filter_ring.sv
// Sample history ring: DEPTH entries with a wrap-around write pointer.
// The entry about to be overwritten is presented combinationally so the
// running sum can subtract it in the same edge that stores the new sample.
module sample_ring
  import temp_filter_pkg::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_wr_en,
  input  logic [TEMP_W-1:0] i_wr_data,
  output logic [TEMP_W-1:0] o_evict_data
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [TEMP_W-1:0]     r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;

  // Store the accepted sample and advance the pointer; DEPTH is a power of
  // two so the pointer wraps DEPTH-1 -> 0 by natural overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      r_wr_ptr        <= r_wr_ptr + LOG2_DEPTH'(1);
    end
  end

  assign o_evict_data = r_mem[r_wr_ptr];

endmodule : sample_ring

// File: rtl/temp_sample_filter.sv
// Boxcar moving-average filter for XADC temperature codes, with a
// hysteretic over-temperature flag driven from the filtered value.
module temp_sample_filter
  import temp_filter_pkg::*;
#(
  parameter int                LOG2_DEPTH = 3,
  parameter logic [TEMP_W-1:0] HI_THRESH  = HI_THRESH_DEF,
  parameter logic [TEMP_W-1:0] LO_THRESH  = LO_THRESH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ready,
  input  logic [TEMP_W-1:0] digitalTemp,
  output logic [TEMP_W-1:0] filteredTemp,
  output logic              filteredValid,
  output logic              overTemp,
  output logic              primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = TEMP_W + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic              r_ready_d;
  logic              w_accept;
  logic              r_accept_d;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_count;
  logic [TEMP_W-1:0] w_evict;
  logic [TEMP_W-1:0] r_filtered;
  logic              r_valid;
  logic              r_primed;
  ot_state_e         r_ot_state;
  ot_state_e         w_ot_next;

  // A sample is taken only on the 0->1 transition of ready.
  assign w_accept = ready & ~r_ready_d;

  sample_ring #(
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .CLK          (CLK),
    .RST          (RST),
    .i_wr_en      (w_accept),
    .i_wr_data    (digitalTemp),
    .o_evict_data (w_evict)
  );

  // Edge history, running sum and saturating fill count. The sum wraps
  // modulo 2^SUM_W mid-expression but the final value always fits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ready_d  <= 1'b0;
      r_accept_d <= 1'b0;
      r_sum      <= '0;
      r_count    <= '0;
    end else begin
      r_ready_d  <= ready;
      r_accept_d <= w_accept;
      if (w_accept) begin
        r_sum <= r_sum + SUM_W'(digitalTemp) - SUM_W'(w_evict);
        if (r_count != DEPTH_C) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  // One cycle after an accept, publish the truncated mean once the window is full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_filtered <= '0;
      r_valid    <= 1'b0;
      r_primed   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_accept_d && (r_count == DEPTH_C)) begin
        r_filtered <= r_sum[SUM_W-1:LOG2_DEPTH];
        r_valid    <= 1'b1;
        r_primed   <= 1'b1;
      end
    end
  end

  // Hysteresis state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ot_state <= OT_OK;
    end else begin
      r_ot_state <= w_ot_next;
    end
  end

  // Hysteresis next state; only re-evaluated while a fresh mean is valid.
  always_comb begin
    w_ot_next = r_ot_state;
    if (r_valid) begin
      case (r_ot_state)
        OT_OK:   w_ot_next = (r_filtered >= HI_THRESH) ? OT_HOT : OT_OK;
        OT_HOT:  w_ot_next = (r_filtered <= LO_THRESH) ? OT_OK : OT_HOT;
        default: w_ot_next = OT_OK;
      endcase
    end else begin
      w_ot_next = r_ot_state;
    end
  end

  // Hysteresis output decode from the registered state.
  always_comb begin
    overTemp = 1'b0;
    case (r_ot_state)
      OT_HOT:  overTemp = 1'b1;
      default: overTemp = 1'b0;
    endcase
  end

  assign filteredTemp  = r_filtered;
  assign filteredValid = r_valid;
  assign primed        = r_primed;

endmodule : temp_sample_filter

// File: tb/tb_temp_sample_filter.sv
// Directed self-checking bench for temp_sample_filter (window of 4 samples).
module tb_temp_sample_filter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ready = 1'b0;
  logic [11:0] digitalTemp = 12'd0;
  logic [11:0] filteredTemp;
  logic        filteredValid;
  logic        overTemp;
  logic        primed;

  int checks = 0;
  int errors = 0;

  temp_sample_filter #(
    .LOG2_DEPTH (2),
    .HI_THRESH  (12'd2500),
    .LO_THRESH  (12'd2400)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ready         (ready),
    .digitalTemp   (digitalTemp),
    .filteredTemp  (filteredTemp),
    .filteredValid (filteredValid),
    .overTemp      (overTemp),
    .primed        (primed)
  );

  always #5 CLK = ~CLK;

  // One-cycle synchronous reset.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Present one sample with a single-cycle ready pulse, then watch 4 cycles
  // for filteredValid: number of valid cycles and first valid cycle (-1 none).
  task automatic push(input logic [11:0] v, output int vcnt, output int vcyc);
    @(negedge CLK);
    ready = 1'b1;
    digitalTemp = v;
    @(posedge CLK);
    #1;
    ready = 1'b0;
    digitalTemp = 12'hABC;
    vcnt = 0;
    vcyc = -1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK);
      #1;
      if (filteredValid) begin
        vcnt++;
        if (vcyc < 0) vcyc = c;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    checks++;
    if (filteredTemp !== 12'd0 || filteredValid !== 1'b0 || overTemp !== 1'b0 || primed !== 1'b0) begin
      errors++;
      $display("FAIL reset got temp=%0d valid=%0b ot=%0b primed=%0b expected 0 0 0 0",
               filteredTemp, filteredValid, overTemp, primed);
    end
  endtask

  task automatic test_basic_mean();
    int vc, vy;
    logic [11:0] vals [3];
    vals[0] = 12'd100; vals[1] = 12'd200; vals[2] = 12'd300;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(vals[i], vc, vy);
      checks++;
      if (vc !== 0 || primed !== 1'b0) begin
        errors++;
        $display("FAIL fill_no_valid[%0d] got valid_cycles=%0d primed=%0b expected 0 0", i, vc, primed);
      end
    end
    push(12'd400, vc, vy);
    checks++;
    if (vc !== 1 || vy !== 1) begin
      errors++;
      $display("FAIL first_valid_timing got count=%0d cycle=%0d expected 1 1", vc, vy);
    end
    checks++;
    if (filteredTemp !== 12'd250 || primed !== 1'b1) begin
      errors++;
      $display("FAIL first_mean got temp=%0d primed=%0b expected 250 1", filteredTemp, primed);
    end
    push(12'd500, vc, vy);
    checks++;
    if (filteredTemp !== 12'd350 || vc !== 1) begin
      errors++;
      $display("FAIL sliding_mean got temp=%0d valid_cycles=%0d expected 350 1", filteredTemp, vc);
    end
  endtask

  task automatic test_truncate_and_max();
    int vc, vy;
    do_reset();
    push(12'd1, vc, vy);
    push(12'd1, vc, vy);
    push(12'd1, vc, vy);
    push(12'd2, vc, vy);
    checks++;
    if (filteredTemp !== 12'd1 || vc !== 1) begin
      errors++;
      $display("FAIL truncate got temp=%0d valid_cycles=%0d expected 1 1", filteredTemp, vc);
    end
    push(12'd4095, vc, vy);
    checks++;
    if (filteredTemp !== 12'd1024) begin
      errors++;
      $display("FAIL partial_max got %0d expected 1024", filteredTemp);
    end
    push(12'd4095, vc, vy);
    push(12'd4095, vc, vy);
    push(12'd4095, vc, vy);
    checks++;
    if (filteredTemp !== 12'd4095) begin
      errors++;
      $display("FAIL full_scale got %0d expected 4095", filteredTemp);
    end
  endtask

  task automatic test_ready_held();
    int vc, vy, seen;
    do_reset();
    seen = 0;
    @(negedge CLK);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      digitalTemp = 12'(40 + i);
      @(negedge CLK);
      if (filteredValid) seen++;
    end
    ready = 1'b0;
    repeat (3) @(negedge CLK);
    push(12'd20, vc, vy);
    checks++;
    if (vc !== 0 || seen !== 0) begin
      errors++;
      $display("FAIL held_single_accept_a got valid_cycles=%0d held_valid=%0d expected 0 0", vc, seen);
    end
    push(12'd20, vc, vy);
    checks++;
    if (vc !== 0) begin
      errors++;
      $display("FAIL held_single_accept_b got valid_cycles=%0d expected 0", vc);
    end
    push(12'd20, vc, vy);
    checks++;
    if (vc !== 1 || filteredTemp !== 12'd25) begin
      errors++;
      $display("FAIL held_first_value got valid_cycles=%0d temp=%0d expected 1 25", vc, filteredTemp);
    end
  endtask

  task automatic test_hysteresis();
    int vc, vy;
    do_reset();
    for (int i = 0; i < 4; i++) push(12'd2500, vc, vy);
    checks++;
    if (overTemp !== 1'b1) begin
      errors++;
      $display("FAIL hyst_set got %0b expected 1", overTemp);
    end
    for (int i = 0; i < 4; i++) push(12'd2450, vc, vy);
    checks++;
    if (overTemp !== 1'b1 || filteredTemp !== 12'd2450) begin
      errors++;
      $display("FAIL hyst_hold_hot got ot=%0b temp=%0d expected 1 2450", overTemp, filteredTemp);
    end
    for (int i = 0; i < 4; i++) push(12'd2400, vc, vy);
    checks++;
    if (overTemp !== 1'b0) begin
      errors++;
      $display("FAIL hyst_clear got %0b expected 0", overTemp);
    end
    for (int i = 0; i < 4; i++) push(12'd2450, vc, vy);
    checks++;
    if (overTemp !== 1'b0) begin
      errors++;
      $display("FAIL hyst_hold_ok got %0b expected 0", overTemp);
    end
  endtask

  task automatic test_reset_midwindow();
    int vc, vy;
    do_reset();
    push(12'd100, vc, vy);
    push(12'd100, vc, vy);
    push(12'd100, vc, vy);
    @(negedge CLK);
    RST = 1'b1;
    ready = 1'b1;
    digitalTemp = 12'd3000;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ready = 1'b0;
    checks++;
    if (filteredTemp !== 12'd0 || filteredValid !== 1'b0 || overTemp !== 1'b0 || primed !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got temp=%0d valid=%0b ot=%0b primed=%0b expected 0 0 0 0",
               filteredTemp, filteredValid, overTemp, primed);
    end
    for (int i = 0; i < 3; i++) begin
      push(12'd800, vc, vy);
      checks++;
      if (vc !== 0) begin
        errors++;
        $display("FAIL midreset_refill[%0d] got valid_cycles=%0d expected 0", i, vc);
      end
    end
    push(12'd800, vc, vy);
    checks++;
    if (vc !== 1 || filteredTemp !== 12'd800 || primed !== 1'b1) begin
      errors++;
      $display("FAIL midreset_mean got valid_cycles=%0d temp=%0d primed=%0b expected 1 800 1",
               vc, filteredTemp, primed);
    end
  endtask

  task automatic test_wraparound();
    int vc, vy;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push(12'(10 * i), vc, vy);
      if (i == 4) begin
        checks++;
        if (filteredTemp !== 12'd25) begin
          errors++;
          $display("FAIL wrap_first got %0d expected 25", filteredTemp);
        end
      end
      if (i == 8) begin
        checks++;
        if (filteredTemp !== 12'd65) begin
          errors++;
          $display("FAIL wrap_second got %0d expected 65", filteredTemp);
        end
      end
    end
    checks++;
    if (filteredTemp !== 12'd75) begin
      errors++;
      $display("FAIL wrap_final got %0d expected 75", filteredTemp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_mean();
    test_truncate_and_max();
    test_ready_held();
    test_hysteresis();
    test_reset_midwindow();
    test_wraparound();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_temp_sample_filter
